pux_si_mc: RTL and testbench
============================

Name: pux_si_mc

Overview:
Parametrised multi-channel successor to the pux_si stream interface.
- Accepts one opcode over an AXI-stream handshake.
- Fetches a variable-length operand vector on each of NCH independent AXI-stream operand channels into internal buffers.
- Launches the compute core and waits for it to finish.
- Returns a completion status over an AXI-stream status channel.
- Sits between the host DMA/stream fabric and the arithmetic core.

Parameters:
OPCW, 8, opcode width; must be > LENW
DATAW, 16, operand word width
NCH, 3, number of operand channels (A, B, M, ...)
DEPTH, 16, max words per operand per channel; power of 2; LENW = clog2(DEPTH)
STATUSW, 2, status width; fixed at 2
TIMEOUT_CYC, 64, idle cycles during fetch before abort; range 1..65535

Ports:
axis_clk  in  1  clock, all logic on rising edge
axis_rstn  in  1  asynchronous active-low reset
axis_opcode_data  in  OPCW  opcode[LENW-1:0] = words-1; opcode[OPCW-1:LENW] = func
axis_opcode_valid  in  1  opcode valid
axis_opcode_ready  out  1  opcode ready
op_data  in  NCH*DATAW  flattened channel data; channel i in bits [i*DATAW +: DATAW]
op_valid  in  NCH  per-channel valid
op_ready  out  NCH  per-channel ready
axis_status_data  out  STATUSW  completion status
axis_status_valid  out  1  status valid
axis_status_ready  in  1  status ready
stream_reqest  out  1  request operand stream fetch from upstream
core_start  out  1  one-cycle core launch pulse
core_func  out  OPCW-LENW  latched func
core_len  out  LENW  latched words-1
core_rd_addr  in  LENW  buffer read address
core_rd_data  out  NCH*DATAW  all channels at core_rd_addr
core_done  in  1  core completion pulse
core_err  in  1  core error flag, sampled with core_done

Behaviour:
- Reset (async, axis_rstn = 0):
  - State goes to IDLE.
  - All outputs are 0, including axis_opcode_ready, and are registered.
  - Channel counters and the timeout timer are cleared. Buffer contents are don't-care.
- axis_opcode_ready rises on the first clock edge after reset release.
- FSM state IDLE:
  - axis_opcode_ready = 1.
  - On valid && ready: latch func and len, then drop ready on the next edge.
  - func == 0: go to REPORT with status 2'b11 (illegal). No stream_reqest, no core_start.
  - Otherwise: go to FETCH. Clear the per-channel counters cnt[i] and the timer.
- FSM state FETCH:
  - stream_reqest is held high for the whole state.
  - op_ready[i] = 1 iff cnt[i] < len+1. Channels are fully independent.
  - An accepted beat (valid && ready) writes buf[i][cnt[i]] and increments cnt[i].
  - A full channel drops ready on the edge after its last beat. Extra beats are not consumed.
  - Timer is cleared on any accepted beat on any channel and increments otherwise.
  - All cnt[i] == len+1: go to RUN. This takes priority over the timeout in the same cycle.
  - Timer reaches TIMEOUT_CYC: go to REPORT with status 2'b10. All op_ready drop.
- FSM state RUN:
  - core_start pulses for exactly 1 cycle, on the first cycle in RUN.
  - Wait for core_done, then go to REPORT with status = core_err ? 2'b01 : 2'b00.
  - core_done arriving in the same cycle as core_start is accepted.
  - core_done in any state other than RUN is ignored.
- FSM state REPORT:
  - axis_status_valid = 1. axis_status_data stays stable until the handshake.
  - On valid && ready: go to IDLE. axis_opcode_ready is re-asserted on the next edge.
  - No opcode is accepted outside IDLE.
- Core buffer read:
  - core_rd_data is registered, with 1-cycle latency from core_rd_addr.
  - An address > core_len returns 0 for all channels.
  - Reads are valid in RUN and REPORT.
- core_func and core_len are held from opcode acceptance until the next opcode acceptance.
- Minimum latency, opcode handshake to axis_status_valid:
  - Illegal opcode: 2 cycles.
  - Legal opcode: len+1 (fetch) + 1 (start) + core latency + 1.
- Reset mid-operation: the transaction is abandoned and no status is emitted. The next opcode after reset is handled normally.

Test Plan:
1. Nominal transaction:
   - Stimulus: opcode 0x12 (func=1, len=2), NCH=3, words A=1,2,3 / B=4,5,6 / M=7,8,9; core_done with core_err=0 five cycles after core_start.
   - Required: stream_reqest high only during FETCH; one core_start pulse; core_rd_addr=1 returns {8,5,2} one cycle later; status 00.
2. Illegal opcode:
   - Stimulus: opcode 0x05 (func=0).
   - Required: status 11 two cycles after the handshake; stream_reqest and core_start stay 0.
3. Channel skew and overrun:
   - Stimulus: opcode 0x12; all 3 words on ch0 first, then ch1, then ch2; ch0 holds a 4th beat valid.
   - Required: op_ready[0] low after its 3rd beat; the 4th beat is not consumed; RUN is entered only after ch2's last beat.
4. Fetch timeout:
   - Stimulus: TIMEOUT_CYC=32, opcode 0x12; ch1 supplies only 2 words.
   - Required: status 10 after 32 idle cycles following the last beat; all op_ready go 0; core_start is never pulsed.
5. Core error with status back-pressure:
   - Stimulus: core_err=1 with core_done; axis_status_ready held low for 10 cycles; opcode_valid asserted meanwhile.
   - Required: status 01 held stable; axis_opcode_ready stays 0 until the status handshake; the new opcode is then accepted.
6. Reset in FETCH:
   - Stimulus: assert axis_rstn=0 after 1 beat.
   - Required: all outputs go 0 asynchronously; after release, opcode 0x20 (func=2, len=0, one word per channel) completes with status 00.

Source files
------------

// File: rtl/pux_si_mc_if.sv
// Bundle of the opcode, operand, status and core-side signals of pux_si_mc.
// The slave modport is the controller's view; master is the host/core side.
interface pux_si_mc_if #(
  parameter int OPCW    = 8,
  parameter int DATAW   = 16,
  parameter int NCH     = 3,
  parameter int DEPTH   = 16,
  parameter int STATUSW = 2
);
  localparam int LENW  = $clog2(DEPTH);
  localparam int FUNCW = OPCW - LENW;

  logic [OPCW-1:0]      axis_opcode_data;
  logic                 axis_opcode_valid;
  logic                 axis_opcode_ready;
  logic [NCH*DATAW-1:0] op_data;
  logic [NCH-1:0]       op_valid;
  logic [NCH-1:0]       op_ready;
  logic [STATUSW-1:0]   axis_status_data;
  logic                 axis_status_valid;
  logic                 axis_status_ready;
  logic                 stream_reqest;
  logic                 core_start;
  logic [FUNCW-1:0]     core_func;
  logic [LENW-1:0]      core_len;
  logic [LENW-1:0]      core_rd_addr;
  logic [NCH*DATAW-1:0] core_rd_data;
  logic                 core_done;
  logic                 core_err;

  modport slave (
    input  axis_opcode_data, axis_opcode_valid,
    output axis_opcode_ready,
    input  op_data, op_valid,
    output op_ready,
    output axis_status_data, axis_status_valid,
    input  axis_status_ready,
    output stream_reqest, core_start, core_func, core_len,
    input  core_rd_addr,
    output core_rd_data,
    input  core_done, core_err
  );

  modport master (
    output axis_opcode_data, axis_opcode_valid,
    input  axis_opcode_ready,
    output op_data, op_valid,
    input  op_ready,
    input  axis_status_data, axis_status_valid,
    output axis_status_ready,
    input  stream_reqest, core_start, core_func, core_len,
    output core_rd_addr,
    input  core_rd_data,
    output core_done, core_err
  );
endinterface

// File: rtl/pux_si_mc.sv
// Multi-channel stream front end for the arithmetic core: takes one opcode,
// gathers an operand vector per channel, runs the core, returns a status.
//
// state    | meaning
// S_IDLE   | opcode ready, waiting for an opcode
// S_FETCH  | stream_reqest high, filling per-channel operand buffers
// S_RUN    | core launched, waiting for core_done
// S_REPORT | status valid, waiting for the status handshake
module pux_si_mc #(
  parameter int OPCW        = 8,
  parameter int DATAW       = 16,
  parameter int NCH         = 3,
  parameter int DEPTH       = 16,
  parameter int STATUSW     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          axis_clk,
  input  logic          axis_rstn,
  pux_si_mc_if.slave    bus
);
  localparam int LENW  = $clog2(DEPTH);
  localparam int FUNCW = OPCW - LENW;
  localparam int CNTW  = LENW + 1;

  localparam logic [15:0]        TMO_LOAD   = 16'(TIMEOUT_CYC);
  localparam logic [STATUSW-1:0] ST_OK      = STATUSW'(0);
  localparam logic [STATUSW-1:0] ST_CERR    = STATUSW'(1);
  localparam logic [STATUSW-1:0] ST_TMO     = STATUSW'(2);
  localparam logic [STATUSW-1:0] ST_ILLEGAL = STATUSW'(3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [FUNCW-1:0]             func_q, func_d;
  logic [LENW-1:0]              len_q, len_d;
  logic [NCH-1:0][CNTW-1:0]     cnt_q, cnt_d;
  logic [15:0]                  tmr_q, tmr_d;
  logic                         opc_ready_q, opc_ready_d;
  logic [NCH-1:0]               op_ready_q, op_ready_d;
  logic                         sreq_q, sreq_d;
  logic                         start_q, start_d;
  logic                         stat_valid_q, stat_valid_d;
  logic [STATUSW-1:0]           stat_data_q, stat_data_d;
  logic [NCH-1:0]               beat;
  logic                         all_full;
  logic                         opc_hs;
  logic [FUNCW-1:0]             opc_func;
  logic [LENW-1:0]              opc_len;
  logic [CNTW-1:0]              words_q, words_d;
  logic [NCH*DATAW-1:0]         rd_data;

  assign opc_hs   = bus.axis_opcode_valid && opc_ready_q;
  assign opc_func = bus.axis_opcode_data[OPCW-1:LENW];
  assign opc_len  = bus.axis_opcode_data[LENW-1:0];
  // word counts are len+1, one bit wider so a full DEPTH fits
  assign words_q  = {1'b0, len_q} + CNTW'(1);
  assign words_d  = {1'b0, len_d} + CNTW'(1);

  // FSM next state, counters, timer and the next value of every registered output
  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    stat_data_d = stat_data_q;
    beat        = '0;
    all_full    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (opc_hs) begin
          func_d = opc_func;
          len_d  = opc_len;
          if (opc_func == '0) begin
            state_d     = S_REPORT;
            stat_data_d = ST_ILLEGAL;
          end else begin
            state_d = S_FETCH;
            cnt_d   = '0;
            tmr_d   = TMO_LOAD;
          end
        end
      end
      S_FETCH: begin
        for (int i = 0; i < NCH; i++) begin
          beat[i] = bus.op_valid[i] && op_ready_q[i];
          if (beat[i]) cnt_d[i] = cnt_q[i] + CNTW'(1);
          if (cnt_d[i] != words_q) all_full = 1'b0;
        end
        // completion wins over a timeout landing in the same cycle
        if (all_full) begin
          state_d = S_RUN;
        end else if (|beat) begin
          tmr_d = TMO_LOAD;
        end else begin
          tmr_d = tmr_q - 16'd1;
          if (tmr_q <= 16'd1) begin
            state_d     = S_REPORT;
            stat_data_d = ST_TMO;
          end
        end
      end
      S_RUN: begin
        if (bus.core_done) begin
          state_d     = S_REPORT;
          stat_data_d = bus.core_err ? ST_CERR : ST_OK;
        end
      end
      S_REPORT: begin
        if (stat_valid_q && bus.axis_status_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    opc_ready_d  = (state_d == S_IDLE);
    sreq_d       = (state_d == S_FETCH);
    start_d      = (state_q == S_FETCH) && (state_d == S_RUN);
    stat_valid_d = (state_d == S_REPORT);
    op_ready_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      op_ready_d[i] = (state_d == S_FETCH) && (cnt_d[i] < words_d);
    end
  end

  // state and control registers
  always_ff @(posedge axis_clk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state_q      <= S_IDLE;
      func_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      opc_ready_q  <= 1'b0;
      op_ready_q   <= '0;
      sreq_q       <= 1'b0;
      start_q      <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      opc_ready_q  <= opc_ready_d;
      op_ready_q   <= op_ready_d;
      sreq_q       <= sreq_d;
      start_q      <= start_d;
      stat_valid_q <= stat_valid_d;
      stat_data_q  <= stat_data_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DATAW-1:0] mem [DEPTH];
    logic [DATAW-1:0] rd_q;

    // operand buffer write; contents are not reset
    always_ff @(posedge axis_clk) begin
      if (beat[g]) mem[cnt_q[g][LENW-1:0]] <= bus.op_data[g*DATAW +: DATAW];
    end

    // registered core read port; addresses past the latched length read as zero
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
      if (!axis_rstn) begin
        rd_q <= '0;
      end else begin
        rd_q <= (bus.core_rd_addr <= len_q) ? mem[bus.core_rd_addr] : '0;
      end
    end

    assign rd_data[g*DATAW +: DATAW] = rd_q;
  end

  assign bus.axis_opcode_ready = opc_ready_q;
  assign bus.op_ready          = op_ready_q;
  assign bus.axis_status_data  = stat_data_q;
  assign bus.axis_status_valid = stat_valid_q;
  assign bus.stream_reqest     = sreq_q;
  assign bus.core_start        = start_q;
  assign bus.core_func         = func_q;
  assign bus.core_len          = len_q;
  assign bus.core_rd_data      = rd_data;
endmodule

// File: tb/tb_pux_si_mc.sv
// Directed bench for pux_si_mc: nominal, illegal opcode, skew/overrun,
// timeout, core error with status back-pressure, reset during fetch.
module tb_pux_si_mc;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   start_cnt = 0;
  int   sreq_cnt = 0;

  logic [15:0] wd [3][8];
  int          wn [3];
  int          wp [3];

  pux_si_mc_if #(.OPCW(8), .DATAW(16), .NCH(3), .DEPTH(16), .STATUSW(2)) bus ();

  pux_si_mc #(.OPCW(8), .DATAW(16), .NCH(3), .DEPTH(16), .STATUSW(2), .TIMEOUT_CYC(32)) dut (
    .axis_clk  (clk),
    .axis_rstn (rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.core_start) start_cnt++;
    if (bus.stream_reqest) sreq_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input int ch, input int n, input int base);
    for (int k = 0; k < n; k++) wd[ch][k] = 16'(base + k);
    wn[ch] = n;
    wp[ch] = 0;
  endtask

  function automatic logic all_fed();
    logic r = 1'b1;
    for (int i = 0; i < 3; i++) if (wp[i] < wn[i]) r = 1'b0;
    return r;
  endfunction

  task automatic fetch_cycle(input logic [2:0] en);
    logic [2:0] v;
    logic [2:0] r;
    for (int i = 0; i < 3; i++) begin
      v[i] = en[i] && (wp[i] < wn[i]);
      bus.op_data[i*16 +: 16] = v[i] ? wd[i][wp[i]] : 16'h0;
    end
    bus.op_valid = v;
    r = bus.op_ready;
    tick();
    for (int i = 0; i < 3; i++) if (v[i] && r[i]) wp[i]++;
  endtask

  task automatic fetch_all(input string tag);
    int n = 0;
    while (!all_fed() && n < 40) begin
      fetch_cycle(3'b111);
      n++;
    end
    bus.op_valid = '0;
    check_eq({tag, "_fed"}, 64'(all_fed()), 64'd1);
  endtask

  task automatic send_op(input string tag, input logic [7:0] op);
    int n = 0;
    bus.axis_opcode_data  = op;
    bus.axis_opcode_valid = 1'b1;
    while (!bus.axis_opcode_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq({tag, "_oprdy"}, 64'(bus.axis_opcode_ready), 64'd1);
    tick();
    bus.axis_opcode_valid = 1'b0;
  endtask

  task automatic pulse_done(input int dly, input logic err);
    repeat (dly) tick();
    bus.core_done = 1'b1;
    bus.core_err  = err;
    tick();
    bus.core_done = 1'b0;
    bus.core_err  = 1'b0;
  endtask

  task automatic take_status(input string tag, input logic [1:0] exp);
    int n = 0;
    while (!bus.axis_status_valid && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_svld"}, 64'(bus.axis_status_valid), 64'd1);
    check_eq({tag, "_scode"}, 64'(bus.axis_status_data), 64'(exp));
    bus.axis_status_ready = 1'b1;
    tick();
    bus.axis_status_ready = 1'b0;
    check_eq({tag, "_sdrop"}, 64'(bus.axis_status_valid), 64'd0);
    check_eq({tag, "_reidle"}, 64'(bus.axis_opcode_ready), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_oprdy"}, 64'(bus.axis_opcode_ready), 64'd0);
    check_eq({tag, "_opr"}, 64'(bus.op_ready), 64'd0);
    check_eq({tag, "_sreq"}, 64'(bus.stream_reqest), 64'd0);
    check_eq({tag, "_start"}, 64'(bus.core_start), 64'd0);
    check_eq({tag, "_svld"}, 64'(bus.axis_status_valid), 64'd0);
    check_eq({tag, "_sdat"}, 64'(bus.axis_status_data), 64'd0);
    check_eq({tag, "_func"}, 64'(bus.core_func), 64'd0);
    check_eq({tag, "_len"}, 64'(bus.core_len), 64'd0);
    check_eq({tag, "_rdd"}, 64'(bus.core_rd_data), 64'd0);
  endtask

  initial begin
    int bad;
    int n;
    bus.axis_opcode_data  = '0;
    bus.axis_opcode_valid = 1'b0;
    bus.op_data           = '0;
    bus.op_valid          = '0;
    bus.axis_status_ready = 1'b0;
    bus.core_rd_addr      = '0;
    bus.core_done         = 1'b0;
    bus.core_err          = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wn[i] = 0;
      wp[i] = 0;
    end

    // reset state
    #1;
    check_quiet("rst");
    repeat (3) tick();
    rstn = 1'b1;
    check_eq("rst_rel_oprdy", 64'(bus.axis_opcode_ready), 64'd0);
    tick();
    check_eq("rst_first_oprdy", 64'(bus.axis_opcode_ready), 64'd1);

    // 1: nominal
    start_cnt = 0;
    sreq_cnt  = 0;
    set_words(0, 3, 1);
    set_words(1, 3, 4);
    set_words(2, 3, 7);
    send_op("t1", 8'h12);
    check_eq("t1_func", 64'(bus.core_func), 64'd1);
    check_eq("t1_len", 64'(bus.core_len), 64'd2);
    check_eq("t1_oprdy_drop", 64'(bus.axis_opcode_ready), 64'd0);
    check_eq("t1_sreq_on", 64'(bus.stream_reqest), 64'd1);
    fetch_all("t1");
    check_eq("t1_start", 64'(bus.core_start), 64'd1);
    check_eq("t1_sreq_off", 64'(bus.stream_reqest), 64'd0);
    pulse_done(5, 1'b0);
    check_eq("t1_svld_now", 64'(bus.axis_status_valid), 64'd1);
    bus.core_rd_addr = 4'd1;
    tick();
    check_eq("t1_rd1", 64'(bus.core_rd_data), {16'h0, 16'd8, 16'd5, 16'd2});
    bus.core_rd_addr = 4'd3;
    tick();
    check_eq("t1_rd_oob", 64'(bus.core_rd_data), 64'd0);
    take_status("t1", 2'b00);
    check_eq("t1_start_cnt", 64'(start_cnt), 64'd1);
    check_eq("t1_sreq_cnt", 64'(sreq_cnt), 64'd3);

    // 2: illegal opcode
    start_cnt = 0;
    sreq_cnt  = 0;
    send_op("t2", 8'h05);
    check_eq("t2_svld", 64'(bus.axis_status_valid), 64'd1);
    check_eq("t2_code", 64'(bus.axis_status_data), 64'd3);
    take_status("t2", 2'b11);
    check_eq("t2_start_cnt", 64'(start_cnt), 64'd0);
    check_eq("t2_sreq_cnt", 64'(sreq_cnt), 64'd0);

    // 3: skew and overrun
    set_words(0, 4, 10);
    set_words(1, 3, 20);
    set_words(2, 3, 30);
    send_op("t3", 8'h12);
    n = 0;
    while (wp[0] < 3 && n < 10) begin
      fetch_cycle(3'b001);
      n++;
    end
    check_eq("t3_ch0_cnt", 64'(wp[0]), 64'd3);
    check_eq("t3_ch0_rdy", 64'(bus.op_ready), 64'b110);
    n = 0;
    while (wp[1] < 3 && n < 10) begin
      fetch_cycle(3'b011);
      n++;
    end
    check_eq("t3_ch1_cnt", 64'(wp[1]), 64'd3);
    bad = 0;
    n = 0;
    while (wp[2] < 3 && n < 10) begin
      if (!bus.stream_reqest || bus.core_start) bad++;
      fetch_cycle(3'b111);
      n++;
    end
    check_eq("t3_wait_ch2", 64'(bad), 64'd0);
    check_eq("t3_start", 64'(bus.core_start), 64'd1);
    check_eq("t3_no_overrun", 64'(wp[0]), 64'd3);
    check_eq("t3_rdy_all_off", 64'(bus.op_ready), 64'd0);
    bus.op_valid = '0;
    bus.core_rd_addr = 4'd2;
    pulse_done(0, 1'b0);
    check_eq("t3_done_with_start", 64'(bus.axis_status_valid), 64'd1);
    check_eq("t3_rd2", 64'(bus.core_rd_data), {16'h0, 16'd32, 16'd22, 16'd12});
    take_status("t3", 2'b00);

    // 4: fetch timeout
    start_cnt = 0;
    set_words(0, 3, 40);
    set_words(1, 2, 50);
    set_words(2, 3, 60);
    send_op("t4", 8'h12);
    fetch_all("t4");
    n = 0;
    while (!bus.axis_status_valid && n < 100) begin
      tick();
      n++;
    end
    check_eq("t4_idle_cycles", 64'(n), 64'd32);
    check_eq("t4_code", 64'(bus.axis_status_data), 64'd2);
    check_eq("t4_rdy_off", 64'(bus.op_ready), 64'd0);
    check_eq("t4_sreq_off", 64'(bus.stream_reqest), 64'd0);
    take_status("t4", 2'b10);
    check_eq("t4_start_cnt", 64'(start_cnt), 64'd0);

    // 5: core error, status back-pressure, opcode waiting
    set_words(0, 3, 1);
    set_words(1, 3, 4);
    set_words(2, 3, 7);
    send_op("t5", 8'h12);
    fetch_all("t5");
    pulse_done(2, 1'b1);
    bus.axis_opcode_data  = 8'h20;
    bus.axis_opcode_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (!bus.axis_status_valid || bus.axis_status_data != 2'b01 || bus.axis_opcode_ready) bad++;
      tick();
    end
    check_eq("t5_hold", 64'(bad), 64'd0);
    check_eq("t5_func_held", 64'(bus.core_func), 64'd1);
    bus.axis_status_ready = 1'b1;
    tick();
    bus.axis_status_ready = 1'b0;
    check_eq("t5_sdrop", 64'(bus.axis_status_valid), 64'd0);
    check_eq("t5_oprdy_back", 64'(bus.axis_opcode_ready), 64'd1);
    tick();
    bus.axis_opcode_valid = 1'b0;
    check_eq("t5_accepted", 64'(bus.axis_opcode_ready), 64'd0);
    check_eq("t5_func2", 64'(bus.core_func), 64'd2);
    check_eq("t5_len0", 64'(bus.core_len), 64'd0);
    set_words(0, 1, 100);
    set_words(1, 1, 200);
    set_words(2, 1, 300);
    fetch_all("t5b");
    check_eq("t5b_start", 64'(bus.core_start), 64'd1);
    pulse_done(1, 1'b0);
    take_status("t5b", 2'b00);

    // 6: reset during fetch
    set_words(0, 3, 1);
    set_words(1, 3, 4);
    set_words(2, 3, 7);
    send_op("t6", 8'h12);
    fetch_cycle(3'b001);
    bus.op_valid = '0;
    check_eq("t6_in_fetch", 64'(bus.stream_reqest), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_quiet("t6_rst");
    tick();
    #2;
    rstn = 1'b1;
    tick();
    check_eq("t6_oprdy", 64'(bus.axis_opcode_ready), 64'd1);
    check_eq("t6_no_status", 64'(bus.axis_status_valid), 64'd0);
    set_words(0, 1, 16'h11);
    set_words(1, 1, 16'h22);
    set_words(2, 1, 16'h33);
    send_op("t6b", 8'h20);
    fetch_all("t6b");
    check_eq("t6b_start", 64'(bus.core_start), 64'd1);
    bus.core_rd_addr = 4'd0;
    pulse_done(3, 1'b0);
    check_eq("t6b_rd0", 64'(bus.core_rd_data), {16'h0, 16'h33, 16'h22, 16'h11});
    take_status("t6b", 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
